bsg_cgol_cell_gen: RTL and testbench
====================================

# bsg_cgol_cell_gen

Parametrised life-like automaton cell: the next-generation cell for the Game of Life array, with a configurable neighbourhood size and runtime-programmable birth/survive rule masks. It also supports multi-state "Generations" decay and keeps per-cell activity statistics. One instance sits at each grid position of the cell array. The array controller drives `en_i` (step), `update_i` (load) and the shared rule masks.

## Interface
- `neighbors_p`, default 8: neighbour count (8 = Moore, 4 = von Neumann); legal 1..15.
- `gen_states_p`, default 2: total cell states including dead and alive; 2 = classic Life, >2 adds decay states; legal 2..16.
- `age_width_p`, default 8: width of the saturating age counter; legal ≥1.

Ports:
- `clk_i`  in  1  single clock, rising edge.
- `reset_n_i`  in  1  reset, asynchronous, active-low.
- `en_i`  in  1  compute one generation.
- `data_i`  in  `neighbors_p`  alive bits of the neighbours.
- `birth_mask_i`  in  `neighbors_p`+1  bit k set: dead cell with k live neighbours is born.
- `survive_mask_i`  in  `neighbors_p`+1  bit k set: alive cell with k live neighbours survives.
- `update_i`  in  1  load state from `update_val_i`.
- `update_val_i`  in  1  1 = alive, 0 = dead.
- `data_o`  out  1  1 when state == ALIVE.
- `state_o`  out  max(1,clog2(`gen_states_p`))  full state.
- `age_o`  out  `age_width_p`  consecutive generations survived.
- `changed_o`  out  1  state changed on the last step or load.

## Operation
- `count` = popcount(`data_i`), width clog2(`neighbors_p`+1); used as the mask index.
- State encoding: 0 = DEAD, 1 = ALIVE, 2..`gen_states_p`-1 = DYING.
- Step transitions, taken when `en_i`=1:
  - DEAD goes to ALIVE if `birth_mask_i[count]`, else stays DEAD.
  - ALIVE stays ALIVE if `survive_mask_i[count]`, else goes to 2 (or DEAD when `gen_states_p`=2).
  - DYING k goes to k+1; the last state (`gen_states_p`-1) wraps to DEAD.
  - Neighbours and masks are ignored while DYING.
- Priority: `en_i` over `update_i`. When `en_i`=1, `update_i` is ignored.
- Load (`update_i`=1, `en_i`=0): state becomes ALIVE or DEAD per `update_val_i`; any DYING state is overwritten.
- Age:
  - ALIVE→ALIVE step: `age_o`+1, saturating at all-ones.
  - Any step or load that leaves the cell ALIVE from a non-ALIVE state: `age_o`=0.
  - Any step or load that leaves the cell non-ALIVE: `age_o`=0.
  - Load of ALIVE onto an already ALIVE cell: `age_o`=0.
- `changed_o` is registered:
  - 1 for the cycle after a step/load whose new state differs from the old state.
  - 0 after a step/load with no change.
  - Holds its value in idle cycles (neither `en_i` nor `update_i`).
- Idle (neither `en_i` nor `update_i`): all state holds.

## Timing
- All outputs are registered. New state, age and `changed_o` are visible one cycle after the edge that samples `en_i`/`update_i`.
- `data_i` and masks are sampled on the same edge as `en_i`; they need not be stable at any other time.
- Back-to-back `en_i` is legal: one generation per cycle.
- Reset (`reset_n_i`=0) is asynchronous and immediate, including mid-decay:
  - state = DEAD, `data_o`=0, `state_o`=0, `age_o`=0, `changed_o`=0.
- Release from reset is synchronous to `clk_i`. The first step can be taken on the first edge after deassertion.

## Configuration
- Macro: `BSG_CGOL_CELL_GEN_AGE_EN`.
  - Defined: age counter is implemented as specified.
  - Undefined: no age register; `age_o` is tied to 0. All other behaviour, including `changed_o`, is unchanged.

## Structure
- Package `bsg_cgol_pkg` holds:
  - state constants `CGOL_DEAD`=0, `CGOL_ALIVE`=1, `CGOL_DYING0`=2;
  - default masks for `neighbors_p`=8: Conway B3/S23 (birth 9'b000001000, survive 9'b000001100) and HighLife B36/S23 (birth 9'b001001000).
- Neighbour counting instantiates the existing basejump `bsg_popcount` with `width_p`=`neighbors_p`.
- One natural sub-module: `bsg_cgol_next_state`, the combinational rule/decay function (count, masks, state → next state).
- Registers stay in the top module.

## Test plan
- Conway defaults (`gen_states_p`=2): DEAD with `data_i`=8'b00000111 + `en_i` → `data_o`=1, `changed_o`=1. ALIVE with 1 neighbour → DEAD. ALIVE with 4 neighbours → DEAD. ALIVE with 2 neighbours → ALIVE, `changed_o`=0.
- HighLife masks: DEAD with 6 neighbours + `en_i` → ALIVE. Same stimulus with Conway masks → stays DEAD.
- `gen_states_p`=4: ALIVE with 0 neighbours, 4 consecutive `en_i` with `data_i`=8'hFF → `state_o` sequence 2,3,0,1. Cell is not born while DYING; it is born only from 0.
- `age_width_p`=2, macro defined: load ALIVE, then 5 surviving steps → `age_o` = 1,2,3,3,3. Then one dying step → `age_o`=0. With macro undefined → `age_o`=0 throughout.
- `en_i`=1 and `update_i`=1 together on DEAD with 3 neighbours, `update_val_i`=0 → ALIVE (step wins). `update_i` alone with `update_val_i`=1 on a DYING cell → `state_o`=1, `age_o`=0.
- Assert `reset_n_i`=0 between clock edges while `state_o`=2 and `age_o`=3 → all outputs 0 immediately, before the next edge.

Source files
------------

// File: rtl/bsg_cgol_pkg.sv
// Shared definitions for the life-like cell array: state encoding,
// stock rule masks for the 8-neighbour (Moore) case, and a width helper.
package bsg_cgol_pkg;

  // State encoding: 0 = dead, 1 = alive, 2 and up = decay (dying) states
  localparam int CGOL_DEAD   = 0;
  localparam int CGOL_ALIVE  = 1;
  localparam int CGOL_DYING0 = 2;

  // Conway B3/S23
  localparam logic [8:0] CGOL_CONWAY_BIRTH     = 9'b000001000;
  localparam logic [8:0] CGOL_CONWAY_SURVIVE   = 9'b000001100;
  // HighLife B36/S23
  localparam logic [8:0] CGOL_HIGHLIFE_BIRTH   = 9'b001001000;
  localparam logic [8:0] CGOL_HIGHLIFE_SURVIVE = 9'b000001100;

  // Bits needed to hold a state index; never narrower than one bit
  function automatic int cgol_state_width(input int gen_states);
    return (gen_states <= 2) ? 1 : $clog2(gen_states);
  endfunction

endpackage

// File: rtl/bsg_cgol_next_state.sv
// Combinational rule/decay function: given the neighbour count, the rule
// masks and the current state, produce the state for the next generation.
module bsg_cgol_next_state
  import bsg_cgol_pkg::*;
#(
  parameter int neighbors_p  = 8,
  parameter int gen_states_p = 2,
  localparam int count_w_lp  = $clog2(neighbors_p+1),
  localparam int state_w_lp  = cgol_state_width(gen_states_p)
) (
  input  logic [count_w_lp-1:0]  count_i,
  input  logic [neighbors_p:0]   birth_mask_i,
  input  logic [neighbors_p:0]   survive_mask_i,
  input  logic [state_w_lp-1:0]  state_i,
  output logic [state_w_lp-1:0]  next_state_o
);

  localparam logic [state_w_lp-1:0] dead_lp   = state_w_lp'(CGOL_DEAD);
  localparam logic [state_w_lp-1:0] alive_lp  = state_w_lp'(CGOL_ALIVE);
  localparam logic [state_w_lp-1:0] dying0_lp = state_w_lp'(CGOL_DYING0);
  localparam logic [state_w_lp-1:0] last_lp   = state_w_lp'(gen_states_p-1);
  // With only two states a failing survivor dies outright instead of decaying
  localparam logic [state_w_lp-1:0] fail_lp   = (gen_states_p == 2) ? dead_lp : dying0_lp;

  // Birth / survival from the masks; decay states ignore neighbours and masks
  always_comb begin
    next_state_o = state_i;
    if (state_i == dead_lp) begin
      next_state_o = birth_mask_i[count_i] ? alive_lp : dead_lp;
    end else if (state_i == alive_lp) begin
      next_state_o = survive_mask_i[count_i] ? alive_lp : fail_lp;
    end else if (state_i == last_lp) begin
      next_state_o = dead_lp;
    end else begin
      next_state_o = state_i + state_w_lp'(1);
    end
  end

endmodule

// File: rtl/bsg_popcount.sv
// Population count of a bit vector.
module bsg_popcount #(
  parameter int width_p = 8
) (
  input  logic [width_p-1:0]               i,
  output logic [$clog2(width_p+1)-1:0]     o
);

  localparam int out_w_lp = $clog2(width_p+1);

  // Sum the set bits
  always_comb begin
    o = '0;
    for (int k = 0; k < width_p; k++) begin
      o = o + out_w_lp'(i[k]);
    end
  end

endmodule

// File: rtl/bsg_cgol_cell_gen.sv
// One cell of the life-like automaton array with Generations-style decay,
// runtime rule masks, a changed flag and an optional saturating age counter.
// Define BSG_CGOL_CELL_GEN_AGE_EN to build the age counter; otherwise age_o
// is tied to zero.
module bsg_cgol_cell_gen
  import bsg_cgol_pkg::*;
#(
  parameter int neighbors_p  = 8,
  parameter int gen_states_p = 2,
  parameter int age_width_p  = 8,
  localparam int count_w_lp  = $clog2(neighbors_p+1),
  localparam int state_w_lp  = cgol_state_width(gen_states_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    en_i,
  input  logic [neighbors_p-1:0]  data_i,
  input  logic [neighbors_p:0]    birth_mask_i,
  input  logic [neighbors_p:0]    survive_mask_i,
  input  logic                    update_i,
  input  logic                    update_val_i,
  output logic                    data_o,
  output logic [state_w_lp-1:0]   state_o,
  output logic [age_width_p-1:0]  age_o,
  output logic                    changed_o
);

  localparam logic [state_w_lp-1:0] dead_lp  = state_w_lp'(CGOL_DEAD);
  localparam logic [state_w_lp-1:0] alive_lp = state_w_lp'(CGOL_ALIVE);

  logic [count_w_lp-1:0] count_p0;
  logic [state_w_lp-1:0] next_p0;
  logic [state_w_lp-1:0] load_p0;
  logic [state_w_lp-1:0] state_p1;
  logic                  changed_p1;

  bsg_popcount #(.width_p(neighbors_p)) u_popcount (
    .i (data_i),
    .o (count_p0)
  );

  bsg_cgol_next_state #(
    .neighbors_p  (neighbors_p),
    .gen_states_p (gen_states_p)
  ) u_next_state (
    .count_i        (count_p0),
    .birth_mask_i   (birth_mask_i),
    .survive_mask_i (survive_mask_i),
    .state_i        (state_p1),
    .next_state_o   (next_p0)
  );

  assign load_p0 = update_val_i ? alive_lp : dead_lp;

  // ---- stage boundary: registered cell state ----
  // State and changed flag; a step takes priority over a load
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_p1   <= dead_lp;
      changed_p1 <= 1'b0;
    end else if (en_i) begin
      state_p1   <= next_p0;
      changed_p1 <= (next_p0 != state_p1);
    end else if (update_i) begin
      state_p1   <= load_p0;
      changed_p1 <= (load_p0 != state_p1);
    end
  end

`ifdef BSG_CGOL_CELL_GEN_AGE_EN
  logic [age_width_p-1:0] age_p1;

  function automatic logic [age_width_p-1:0] sat_inc(input logic [age_width_p-1:0] a);
    return (&a) ? a : a + age_width_p'(1);
  endfunction

  // Age grows only across alive-to-alive steps; every load or other step clears it
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      age_p1 <= '0;
    end else if (en_i) begin
      age_p1 <= ((state_p1 == alive_lp) && (next_p0 == alive_lp)) ? sat_inc(age_p1) : '0;
    end else if (update_i) begin
      age_p1 <= '0;
    end
  end

  assign age_o = age_p1;
`else
  assign age_o = '0;
`endif

  assign state_o   = state_p1;
  assign data_o    = (state_p1 == alive_lp);
  assign changed_o = changed_p1;

endmodule

// File: tb/tb_bsg_cgol_cell_gen.sv
// Directed bench for bsg_cgol_cell_gen: a two-state Conway/HighLife cell
// (u_life) and a four-state Generations cell (u_gen), both with 2-bit age.
module tb_bsg_cgol_cell_gen;
  import bsg_cgol_pkg::*;

`ifdef BSG_CGOL_CELL_GEN_AGE_EN
  localparam bit age_en_lp = 1'b1;
`else
  localparam bit age_en_lp = 1'b0;
`endif

  localparam logic [8:0] b38_lp = 9'b100001000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // life cell
  logic       en_a = 0, upd_a = 0, uval_a = 0;
  logic [7:0] d_a = 0;
  logic [8:0] bm_a = 0, sm_a = 0;
  logic       dout_a, chg_a;
  logic [0:0] st_a;
  logic [1:0] age_a;

  // generations cell
  logic       en_b = 0, upd_b = 0, uval_b = 0;
  logic [7:0] d_b = 0;
  logic [8:0] bm_b = 0, sm_b = 0;
  logic       dout_b, chg_b;
  logic [1:0] st_b;
  logic [1:0] age_b;

  int n_checks = 0;
  int n_pass   = 0;

  bsg_cgol_cell_gen #(.neighbors_p(8), .gen_states_p(2), .age_width_p(2)) u_life (
    .clk_i(clk), .reset_n_i(rst_n), .en_i(en_a), .data_i(d_a),
    .birth_mask_i(bm_a), .survive_mask_i(sm_a), .update_i(upd_a),
    .update_val_i(uval_a), .data_o(dout_a), .state_o(st_a), .age_o(age_a),
    .changed_o(chg_a)
  );

  bsg_cgol_cell_gen #(.neighbors_p(8), .gen_states_p(4), .age_width_p(2)) u_gen (
    .clk_i(clk), .reset_n_i(rst_n), .en_i(en_b), .data_i(d_b),
    .birth_mask_i(bm_b), .survive_mask_i(sm_b), .update_i(upd_b),
    .update_val_i(uval_b), .data_o(dout_b), .state_o(st_b), .age_o(age_b),
    .changed_o(chg_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [31:0] age_exp(input int v);
    return age_en_lp ? 32'(v) : 32'd0;
  endfunction

  // Drive the life cell for one edge, generations cell idle
  task automatic tick_a(input logic en, input logic upd, input logic uval,
                        input logic [7:0] d, input logic [8:0] bm, input logic [8:0] sm);
    en_b = 0; upd_b = 0;
    en_a = en; upd_a = upd; uval_a = uval; d_a = d; bm_a = bm; sm_a = sm;
    @(posedge clk); #1;
    en_a = 0; upd_a = 0;
  endtask

  // Drive the generations cell for one edge, life cell idle
  task automatic tick_b(input logic en, input logic upd, input logic uval, input logic [7:0] d);
    en_a = 0; upd_a = 0;
    en_b = en; upd_b = upd; uval_b = uval; d_b = d;
    bm_b = b38_lp; sm_b = CGOL_CONWAY_SURVIVE;
    @(posedge clk); #1;
    en_b = 0; upd_b = 0;
  endtask

  task automatic idle();
    en_a = 0; upd_a = 0; en_b = 0; upd_b = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    int exp_st_b[4];
    int exp_age_s[5];
    exp_st_b  = '{2, 3, 0, 1};
    exp_age_s = '{1, 2, 3, 3, 3};

    // Reset state, without any clock edge
    #2;
    check("rst_a_data", dout_a, 0);
    check("rst_a_state", st_a, 0);
    check("rst_a_age", age_a, 0);
    check("rst_a_chg", chg_a, 0);
    check("rst_b_state", st_b, 0);
    #10 rst_n = 1'b1;

    // Conway birth on 3 neighbours
    tick_a(1, 0, 0, 8'b00000111, CGOL_CONWAY_BIRTH, CGOL_CONWAY_SURVIVE);
    check("birth_data", dout_a, 1);
    check("birth_chg", chg_a, 1);
    check("birth_age", age_a, 0);
    // Underpopulation
    tick_a(1, 0, 0, 8'h01, CGOL_CONWAY_BIRTH, CGOL_CONWAY_SURVIVE);
    check("lonely_data", dout_a, 0);
    check("lonely_chg", chg_a, 1);
    // Load alive then overcrowd
    tick_a(0, 1, 1, 8'h00, CGOL_CONWAY_BIRTH, CGOL_CONWAY_SURVIVE);
    check("load_alive", dout_a, 1);
    tick_a(1, 0, 0, 8'h0F, CGOL_CONWAY_BIRTH, CGOL_CONWAY_SURVIVE);
    check("crowd_data", dout_a, 0);
    // Survive with 2
    tick_a(0, 1, 1, 8'h00, CGOL_CONWAY_BIRTH, CGOL_CONWAY_SURVIVE);
    tick_a(1, 0, 0, 8'h03, CGOL_CONWAY_BIRTH, CGOL_CONWAY_SURVIVE);
    check("surv_data", dout_a, 1);
    check("surv_chg", chg_a, 0);
    check("surv_age", age_a, age_exp(1));
    idle();
    check("idle_state", st_a, 1);
    check("idle_age", age_a, age_exp(1));

    // Reload alive clears age; then saturating survival
    tick_a(0, 1, 1, 8'h00, CGOL_CONWAY_BIRTH, CGOL_CONWAY_SURVIVE);
    check("reload_age", age_a, 0);
    check("reload_chg", chg_a, 0);
    for (int k = 0; k < 5; k++) begin
      tick_a(1, 0, 0, 8'h03, CGOL_CONWAY_BIRTH, CGOL_CONWAY_SURVIVE);
      check($sformatf("age_step%0d", k), age_a, age_exp(exp_age_s[k]));
    end
    tick_a(1, 0, 0, 8'h00, CGOL_CONWAY_BIRTH, CGOL_CONWAY_SURVIVE);
    check("die_age", age_a, 0);
    check("die_data", dout_a, 0);
    idle();
    check("chg_hold", chg_a, 1);

    // HighLife birth on 6, Conway does not
    tick_a(1, 0, 0, 8'h3F, CGOL_HIGHLIFE_BIRTH, CGOL_HIGHLIFE_SURVIVE);
    check("hl_birth", dout_a, 1);
    tick_a(0, 1, 0, 8'h00, CGOL_CONWAY_BIRTH, CGOL_CONWAY_SURVIVE);
    check("load_dead", dout_a, 0);
    tick_a(1, 0, 0, 8'h3F, CGOL_CONWAY_BIRTH, CGOL_CONWAY_SURVIVE);
    check("conway_no6", dout_a, 0);
    check("conway_no6_chg", chg_a, 0);

    // Step wins over load
    tick_a(1, 1, 0, 8'b00000111, CGOL_CONWAY_BIRTH, CGOL_CONWAY_SURVIVE);
    check("prio_data", dout_a, 1);

    // Generations decay: 2,3,0,1 with all neighbours alive
    tick_b(0, 1, 1, 8'h00);
    check("gen_load", st_b, 1);
    for (int k = 0; k < 4; k++) begin
      tick_b(1, 0, 0, 8'hFF);
      check($sformatf("gen_state%0d", k), st_b, exp_st_b[k]);
      check($sformatf("gen_data%0d", k), dout_b, (exp_st_b[k] == 1) ? 1 : 0);
    end
    // Load alive over a dying cell
    tick_b(1, 0, 0, 8'h00);
    check("gen_dying", st_b, 2);
    tick_b(0, 1, 1, 8'h00);
    check("gen_reload", st_b, 1);
    check("gen_reload_age", age_b, 0);
    check("gen_reload_chg", chg_b, 1);

    // Build age 3 on life cell and state 2 on gen cell, then async reset
    for (int k = 0; k < 3; k++)
      tick_a(1, 0, 0, 8'h03, CGOL_CONWAY_BIRTH, CGOL_CONWAY_SURVIVE);
    check("pre_rst_age", age_a, age_exp(3));
    tick_b(1, 0, 0, 8'h00);
    check("pre_rst_state", st_b, 2);
    #3 rst_n = 1'b0;
    #1;
    check("arst_a_data", dout_a, 0);
    check("arst_a_age", age_a, 0);
    check("arst_a_chg", chg_a, 0);
    check("arst_b_state", st_b, 0);
    check("arst_b_chg", chg_b, 0);
    #2 rst_n = 1'b1;
    // First edge after release steps
    tick_a(1, 0, 0, 8'b00000111, CGOL_CONWAY_BIRTH, CGOL_CONWAY_SURVIVE);
    check("post_rst_birth", dout_a, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
